// File: rtl/axi4_b_sender.sv
`timescale 1ns/1ps
// axi4_b_sender: write-response stage of the RAB write path.
// Forwards master-side B responses to the slave side and injects local
// responses for write bursts the TLB dropped. An injection is released only
// after the W sender reports that the burst's data has been drained.
module axi4_b_sender #(
    parameter int AXI_ID_WIDTH    = 10,
    parameter int AXI_USER_WIDTH  = 2,
    parameter int DROP_FIFO_DEPTH = 4
) (
    input  logic                      axi4_aclk,
    input  logic                      axi4_arst,

    input  logic                      drop_valid,
    input  logic [AXI_ID_WIDTH-1:0]   drop_id,
    input  logic                      drop_prefetch,
    output logic                      drop_ready,

    input  logic                      wlast_received,
    output logic                      response_sent,

    output logic [AXI_ID_WIDTH-1:0]   s_axi4_bid,
    output logic [1:0]                s_axi4_bresp,
    output logic [AXI_USER_WIDTH-1:0] s_axi4_buser,
    output logic                      s_axi4_bvalid,
    input  logic                      s_axi4_bready,

    input  logic [AXI_ID_WIDTH-1:0]   m_axi4_bid,
    input  logic [1:0]                m_axi4_bresp,
    input  logic [AXI_USER_WIDTH-1:0] m_axi4_buser,
    input  logic                      m_axi4_bvalid,
    output logic                      m_axi4_bready
);

    localparam int PTR_W = $clog2(DROP_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(DROP_FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_INJ  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Drop FIFO: each entry is {prefetch, id}.
    logic [AXI_ID_WIDTH:0]     r_fifo_mem [DROP_FIFO_DEPTH];
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [CNT_W-1:0]          r_count;

    // Number of FIFO entries (from the head) whose W data is fully drained.
    logic [CNT_W-1:0]          r_ndrained;
    logic [CNT_W-1:0]          w_ndrained_nxt;

    logic [1:0]                r_state;
    logic                      r_last_grant_inj;
    logic [AXI_ID_WIDTH-1:0]   r_bid;
    logic [1:0]                r_bresp;
    logic [AXI_USER_WIDTH-1:0] r_buser;

    logic                      w_push;
    logic                      w_pop;
    logic                      w_s_hs;
    logic                      w_idle;
    logic                      w_wlast_ok;
    logic                      w_inject_ok;
    logic                      w_grant_fwd;
    logic                      w_grant_inj;
    logic [AXI_ID_WIDTH:0]     w_head;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_s_hs      = s_axi4_bvalid & s_axi4_bready;
    assign w_pop       = w_s_hs & (r_state == ST_INJ);
    assign w_push      = drop_valid & drop_ready;
    // A drain pulse only counts if an undrained entry is actually pending.
    assign w_wlast_ok  = wlast_received & (r_ndrained < r_count);
    assign w_inject_ok = (r_ndrained != '0);
    assign w_head      = r_fifo_mem[r_rd_ptr];

    // Round-robin between the two sources when both are ready in IDLE.
    assign w_grant_fwd = w_idle & m_axi4_bvalid & (~w_inject_ok | r_last_grant_inj);
    assign w_grant_inj = w_idle & w_inject_ok & (~m_axi4_bvalid | ~r_last_grant_inj);

    assign drop_ready    = (r_count != FIFO_FULL);
    assign response_sent = w_pop;
    assign m_axi4_bready = w_grant_fwd;
    assign s_axi4_bvalid = ~w_idle;
    assign s_axi4_bid    = r_bid;
    assign s_axi4_bresp  = r_bresp;
    assign s_axi4_buser  = r_buser;

    // Store dropped-burst entries.
    // NOTE: the storage array has no reset; validity is tracked by r_count,
    // and leaving it out of reset lets it map onto plain RAM/register cells.
    always_ff @(posedge axi4_aclk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {drop_prefetch, drop_id};
        end
    end

    // FIFO pointers and occupancy.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
        if (axi4_arst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Next value of the drained counter: increment and decrement cancel out.
    // NOTE: the default assignment first guarantees no latch is inferred.
    always_comb begin
        w_ndrained_nxt = r_ndrained;
        if (w_wlast_ok && !w_pop) begin
            w_ndrained_nxt = r_ndrained + CNT_W'(1);
        end else if (!w_wlast_ok && w_pop) begin
            w_ndrained_nxt = r_ndrained - CNT_W'(1);
        end
    end

    // Drained counter register.
    always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
        if (axi4_arst) begin
            r_ndrained <= '0;
        end else begin
            r_ndrained <= w_ndrained_nxt;
        end
    end

    // Response FSM: grant a source in IDLE, hold the payload until accepted.
    always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
        if (axi4_arst) begin
            r_state          <= ST_IDLE;
            r_last_grant_inj <= 1'b1;
            r_bid            <= '0;
            r_bresp          <= '0;
            r_buser          <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_fwd) begin
                        r_state          <= ST_FWD;
                        r_last_grant_inj <= 1'b0;
                        r_bid            <= m_axi4_bid;
                        r_bresp          <= m_axi4_bresp;
                        r_buser          <= m_axi4_buser;
                    end else if (w_grant_inj) begin
                        r_state          <= ST_INJ;
                        r_last_grant_inj <= 1'b1;
                        r_bid            <= w_head[AXI_ID_WIDTH-1:0];
                        r_bresp          <= w_head[AXI_ID_WIDTH] ? RESP_OKAY : RESP_SLVERR;
                        r_buser          <= '0;
                    end
                end
                default: begin
                    if (s_axi4_bready) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_b_sender.sv
`timescale 1ns/1ps
// Self-checking bench for axi4_b_sender: a transaction-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_axi4_b_sender;

    localparam int IDW   = 10;
    localparam int UW    = 2;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           arst = 1'b1;
    logic           drop_valid = 1'b0;
    logic [IDW-1:0] drop_id = '0;
    logic           drop_prefetch = 1'b0;
    logic           drop_ready;
    logic           wlast_received = 1'b0;
    logic           response_sent;
    logic [IDW-1:0] s_bid;
    logic [1:0]     s_bresp;
    logic [UW-1:0]  s_buser;
    logic           s_bvalid;
    logic           s_bready = 1'b0;
    logic [IDW-1:0] m_bid = '0;
    logic [1:0]     m_bresp = '0;
    logic [UW-1:0]  m_buser = '0;
    logic           m_bvalid = 1'b0;
    logic           m_bready;

    always #5 clk = ~clk;

    axi4_b_sender #(
        .AXI_ID_WIDTH   (IDW),
        .AXI_USER_WIDTH (UW),
        .DROP_FIFO_DEPTH(DEPTH)
    ) dut (
        .axi4_aclk     (clk),
        .axi4_arst     (arst),
        .drop_valid    (drop_valid),
        .drop_id       (drop_id),
        .drop_prefetch (drop_prefetch),
        .drop_ready    (drop_ready),
        .wlast_received(wlast_received),
        .response_sent (response_sent),
        .s_axi4_bid    (s_bid),
        .s_axi4_bresp  (s_bresp),
        .s_axi4_buser  (s_buser),
        .s_axi4_bvalid (s_bvalid),
        .s_axi4_bready (s_bready),
        .m_axi4_bid    (m_bid),
        .m_axi4_bresp  (m_bresp),
        .m_axi4_buser  (m_buser),
        .m_axi4_bvalid (m_bvalid),
        .m_axi4_bready (m_bready)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending drops as a queue, drained count as an integer,
    // and one optional held response with its origin.
    typedef struct packed {
        logic           pf;
        logic [IDW-1:0] id;
    } drop_t;

    drop_t          mq[$];
    int             md;
    bit             mbusy, minj, mlast_inj;
    logic [IDW-1:0] mid;
    logic [1:0]     mresp;
    logic [UW-1:0]  muser;
    bit             e_idle, e_inj_ok, e_gfwd, e_ginj, e_sent, e_dready, e_wok, e_push;
    logic [IDW-1:0] obs[$];

    always @(negedge clk) begin
        if (arst) begin
            mq.delete();
            md = 0; mbusy = 0; minj = 0; mlast_inj = 1;
            mid = '0; mresp = '0; muser = '0;
            check("rst_bvalid", s_bvalid, 0);
            check("rst_bid", s_bid, 0);
            check("rst_bresp", s_bresp, 0);
            check("rst_buser", s_buser, 0);
            check("rst_mready", m_bready, 0);
            check("rst_sent", response_sent, 0);
            check("rst_dready", drop_ready, 1);
        end else begin
            e_idle   = !mbusy;
            e_inj_ok = md > 0;
            e_gfwd   = e_idle && m_bvalid && (!e_inj_ok || mlast_inj);
            e_ginj   = e_idle && e_inj_ok && (!m_bvalid || !mlast_inj);
            e_sent   = mbusy && minj && s_bready;
            e_dready = mq.size() < DEPTH;
            check("m_bready", m_bready, e_gfwd);
            check("s_bvalid", s_bvalid, mbusy);
            check("response_sent", response_sent, e_sent);
            check("drop_ready", drop_ready, e_dready);
            if (mbusy) begin
                check("s_bid", s_bid, mid);
                check("s_bresp", s_bresp, mresp);
                check("s_buser", s_buser, muser);
            end
            if (s_bvalid && s_bready) obs.push_back(s_bid);
            // advance the model to the state after the coming rising edge
            e_wok  = wlast_received && (md < mq.size());
            e_push = drop_valid && e_dready;
            md = md + int'(e_wok) - int'(e_sent);
            if (e_sent) void'(mq.pop_front());
            if (mbusy && s_bready) mbusy = 0;
            if (e_gfwd) begin
                mbusy = 1; minj = 0; mlast_inj = 0;
                mid = m_bid; mresp = m_bresp; muser = m_buser;
            end else if (e_ginj) begin
                mbusy = 1; minj = 1; mlast_inj = 1;
                mid = mq[0].id; mresp = mq[0].pf ? 2'b00 : 2'b10; muser = '0;
            end
            if (e_push) mq.push_back('{pf: drop_prefetch, id: drop_id});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_drop(input logic [IDW-1:0] id, input logic pf, input logic [1:0] exp_resp);
        drop_valid = 1; drop_id = id; drop_prefetch = pf;
        tick();
        drop_valid = 0;
        tick();
        tick();
        wlast_received = 1;
        tick();
        wlast_received = 0;
        tick();
        @(negedge clk);
        check("drop_bvalid", s_bvalid, 1);
        check("drop_bid", s_bid, id);
        check("drop_bresp", s_bresp, exp_resp);
        check("drop_sent", response_sent, 1);
        tick();
    endtask

    task automatic check_obs(input string name, input int n, input logic [IDW-1:0] ids [4]);
        check({name, "_count"}, obs.size(), n);
        for (int i = 0; i < n; i++) begin
            check(name, (i < obs.size()) ? obs[i] : '1, ids[i]);
        end
    endtask

    logic [IDW-1:0] exp_ids [4];

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("lit_rst_dready", drop_ready, 1);
        check("lit_rst_bvalid", s_bvalid, 0);
        tick();
        arst = 0;

        // pure forward
        m_bvalid = 1; m_bid = 10'h005; m_bresp = 2'b00; s_bready = 1;
        @(negedge clk);
        check("fwd_mready", m_bready, 1);
        tick();
        m_bvalid = 0;
        @(negedge clk);
        check("fwd_bvalid", s_bvalid, 1);
        check("fwd_bid", s_bid, 10'h005);
        check("fwd_sent", response_sent, 0);
        tick();
        @(negedge clk);
        check("fwd_bvalid_once", s_bvalid, 0);
        tick();

        // drop then drain, SLVERR and prefetch OKAY
        run_drop(10'h012, 1'b0, 2'b10);
        run_drop(10'h013, 1'b1, 2'b00);

        // fill the FIFO, order of injected responses, drop_ready recovery
        obs.delete();
        for (int i = 1; i <= 4; i++) begin
            drop_valid = 1; drop_id = IDW'(i); drop_prefetch = 0;
            tick();
        end
        drop_id = 10'h005;
        @(negedge clk);
        check("full_dready", drop_ready, 0);
        tick();
        drop_valid = 0;
        wlast_received = 1;
        tick();
        wlast_received = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (response_sent) break;
        end
        check("first_pop_seen", response_sent, 1);
        check("pop_cycle_dready", drop_ready, 0);
        @(negedge clk);
        check("after_pop_dready", drop_ready, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            wlast_received = 1;
            tick();
        end
        wlast_received = 0;
        repeat (12) tick();
        exp_ids = '{10'h001, 10'h002, 10'h003, 10'h004};
        check_obs("order_id", 4, exp_ids);

        // drain pulse with an empty FIFO creates nothing
        obs.delete();
        wlast_received = 1;
        tick();
        wlast_received = 0;
        tick();
        drop_valid = 1; drop_id = 10'h044; drop_prefetch = 0;
        tick();
        drop_valid = 0;
        repeat (5) tick();
        check("phantom_count", obs.size(), 0);
        wlast_received = 1;
        tick();
        wlast_received = 0;
        repeat (4) tick();
        exp_ids = '{10'h044, 10'h000, 10'h000, 10'h000};
        check_obs("late_drain_id", 1, exp_ids);

        // drain pulse coinciding with an injected handshake is kept
        obs.delete();
        s_bready = 0;
        drop_valid = 1; drop_id = 10'h051;
        tick();
        drop_id = 10'h052;
        tick();
        drop_valid = 0;
        wlast_received = 1;
        tick();
        wlast_received = 0;
        repeat (3) tick();
        s_bready = 1;
        wlast_received = 1;
        @(negedge clk);
        check("coin_sent", response_sent, 1);
        tick();
        wlast_received = 0;
        repeat (6) tick();
        exp_ids = '{10'h051, 10'h052, 10'h000, 10'h000};
        check_obs("coin_id", 2, exp_ids);

        // contention from reset: forward first, then alternate
        arst = 1;
        tick();
        tick();
        arst = 0;
        obs.delete();
        drop_valid = 1; drop_id = 10'h021; drop_prefetch = 1;
        tick();
        drop_id = 10'h022;
        tick();
        drop_valid = 0;
        wlast_received = 1;
        tick();
        m_bvalid = 1; m_bid = 10'h030; m_bresp = 2'b00; m_buser = 2'b00;
        tick();
        wlast_received = 0;
        repeat (4) tick();
        m_bvalid = 0;
        repeat (5) tick();
        exp_ids = '{10'h030, 10'h021, 10'h030, 10'h022};
        check_obs("arb_id", 4, exp_ids);

        // backpressure: payload held, master side stalled
        s_bready = 0;
        m_bvalid = 1; m_bid = 10'h03A; m_bresp = 2'b01; m_buser = 2'b10;
        @(negedge clk);
        check("bp_grant", m_bready, 1);
        tick();
        m_bid = 10'h03B; m_bresp = 2'b00; m_buser = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_bvalid", s_bvalid, 1);
            check("bp_bid", s_bid, 10'h03A);
            check("bp_bresp", s_bresp, 2'b01);
            check("bp_buser", s_buser, 2'b10);
            check("bp_mready", m_bready, 0);
            tick();
        end
        s_bready = 1;
        tick();
        tick();
        m_bvalid = 0;
        repeat (3) tick();

        // reset while an injected response is held
        drop_valid = 1; drop_id = 10'h061; drop_prefetch = 0;
        tick();
        drop_valid = 0;
        s_bready = 0;
        wlast_received = 1;
        tick();
        wlast_received = 0;
        repeat (3) tick();
        @(negedge clk);
        check("inj_held", s_bvalid, 1);
        #2;
        arst = 1;
        #1;
        check("async_bvalid", s_bvalid, 0);
        check("async_dready", drop_ready, 1);
        tick();
        tick();
        arst = 0;
        s_bready = 1;
        obs.delete();
        wlast_received = 1;
        tick();
        wlast_received = 0;
        repeat (6) tick();
        check("post_rst_count", obs.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
